// File: rtl/cp0_trap_sequencer.sv
// cp0_trap_sequencer: steers the CP0 datapath through exception entry and ERET return.
// It also raises the CP0 timer interrupt when Count matches Compare.
// Optional build macro TRAP_STATS_EN adds the trap_count/eret_count statistic outputs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for an exception or ERET at a commit boundary
// FLUSH    | younger stages killed for FLUSH_CYCLES cycles
// SAVE     | one-cycle strobe so EPC/Cause/Status latch
// REDIRECT | fetch redirected to the handler, waiting for ack
// RET      | fetch redirected to the latched EPC, waiting for ack
module cp0_trap_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_boundary,
    input  logic [31:0] commit_pc,
    input  logic        pendingexception,
    input  logic        eret_commit,
    input  logic [31:0] epc,
    input  logic        redirect_ack,
    input  logic [31:0] count,
    input  logic [31:0] compare,
    input  logic        compare_write,
    output logic        flush,
    output logic        stall_core,
    output logic        busy,
    output logic        cp0_activeexception,
    output logic        cp0_eret,
    output logic [31:0] cp0_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_target,
    output logic        in_handler,
    output logic        timer_irq
`ifdef TRAP_STATS_EN
    ,
    output logic [15:0] trap_count,
    output logic [15:0] eret_count
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        SAVE     = 3'd2,
        REDIRECT = 3'd3,
        RET      = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_next;
    logic [3:0]  flush_cnt, flush_cnt_next;
    logic [31:0] cp0_pc_next, target_next;
    logic        in_handler_next;
    logic        flush_next, busy_next, act_next, eret_next, valid_next;

    // Next-state and next-output decode; every output is then registered.
    always_comb begin
        state_next      = state;
        flush_cnt_next  = flush_cnt;
        cp0_pc_next     = cp0_pc;
        target_next     = redirect_target;
        in_handler_next = in_handler;
        case (state)
            IDLE: begin
                if (instr_boundary && pendingexception) begin
                    state_next     = FLUSH;
                    cp0_pc_next    = commit_pc;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (instr_boundary && eret_commit) begin
                    state_next  = RET;
                    target_next = epc;
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) state_next = SAVE;
                else                   flush_cnt_next = flush_cnt - 4'd1;
            end
            SAVE: begin
                state_next  = REDIRECT;
                target_next = HANDLER_ADDR;
            end
            REDIRECT: begin
                if (redirect_ack) begin
                    state_next      = IDLE;
                    in_handler_next = 1'b1;
                end
            end
            RET: begin
                if (redirect_ack) begin
                    state_next      = IDLE;
                    in_handler_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next  = (state_next != IDLE);
        flush_next = busy_next;
        act_next   = (state_next == SAVE);
        // ERET strobe only on the entry edge so it is one cycle per return.
        eret_next  = (state == IDLE) && (state_next == RET);
        valid_next = (state_next == REDIRECT) || (state_next == RET);
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            flush_cnt           <= 4'd0;
            cp0_pc              <= 32'd0;
            redirect_target     <= 32'd0;
            in_handler          <= 1'b0;
            flush               <= 1'b0;
            busy                <= 1'b0;
            cp0_activeexception <= 1'b0;
            cp0_eret            <= 1'b0;
            redirect_valid      <= 1'b0;
        end else begin
            state               <= state_next;
            flush_cnt           <= flush_cnt_next;
            cp0_pc              <= cp0_pc_next;
            redirect_target     <= target_next;
            in_handler          <= in_handler_next;
            flush               <= flush_next;
            busy                <= busy_next;
            cp0_activeexception <= act_next;
            cp0_eret            <= eret_next;
            redirect_valid      <= valid_next;
        end
    end

    assign stall_core = busy;

    // Timer interrupt: sticky on Count==Compare, cleared only by a Compare write.
    always_ff @(posedge clk) begin
        if (reset)                  timer_irq <= 1'b0;
        else if (compare_write)     timer_irq <= 1'b0;
        else if (count == compare)  timer_irq <= 1'b1;
    end

`ifdef TRAP_STATS_EN
    // Statistics count the strobe cycles themselves; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_count <= 16'd0;
            eret_count <= 16'd0;
        end else begin
            if (cp0_activeexception) trap_count <= trap_count + 16'd1;
            if (cp0_eret)            eret_count <= eret_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cp0_trap_sequencer.sv
// Directed bench for cp0_trap_sequencer: exception entry timing, priority, ERET hold,
// reset mid-handshake and the Count/Compare timer.
`timescale 1ns/1ps
module tb_cp0_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_boundary, pendingexception, eret_commit, redirect_ack, compare_write;
    logic [31:0] commit_pc, epc, count, compare;
    logic        flush, stall_core, busy, cp0_activeexception, cp0_eret;
    logic [31:0] cp0_pc, redirect_target;
    logic        redirect_valid, in_handler, timer_irq;
`ifdef TRAP_STATS_EN
    logic [15:0] trap_count, eret_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_act   = 0;
    int n_eret  = 0;

    cp0_trap_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .instr_boundary      (instr_boundary),
        .commit_pc           (commit_pc),
        .pendingexception    (pendingexception),
        .eret_commit         (eret_commit),
        .epc                 (epc),
        .redirect_ack        (redirect_ack),
        .count               (count),
        .compare             (compare),
        .compare_write       (compare_write),
        .flush               (flush),
        .stall_core          (stall_core),
        .busy                (busy),
        .cp0_activeexception (cp0_activeexception),
        .cp0_eret            (cp0_eret),
        .cp0_pc              (cp0_pc),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .in_handler          (in_handler),
        .timer_irq           (timer_irq)
`ifdef TRAP_STATS_EN
        ,
        .trap_count          (trap_count),
        .eret_count          (eret_count)
`endif
    );

    always #5 clk = ~clk;

    // Count strobe cycles mid-cycle to catch pulses wider than one cycle.
    always @(negedge clk) begin
        if (!reset) begin
            n_act  += int'(cp0_activeexception);
            n_eret += int'(cp0_eret);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        instr_boundary = 0; pendingexception = 0; eret_commit = 0; redirect_ack = 0;
        compare_write = 0; commit_pc = 0; epc = 0;
        count = 32'd0; compare = 32'hFFFF_FFFF;
        tick(); tick();
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_flush",  {31'd0, flush}, 32'd0);
        chk("rst_valid",  {31'd0, redirect_valid}, 32'd0);
        chk("rst_target", redirect_target, 32'd0);
        chk("rst_irq",    {31'd0, timer_irq}, 32'd0);
        reset = 1'b0;

        // Exception entry timing, cycle 0 = boundary.
        pendingexception = 1; instr_boundary = 1; commit_pc = 32'h0040_0010;
        tick();                                                   // cycle 1
        pendingexception = 0; instr_boundary = 0;
        chk("c1_flush", {31'd0, flush}, 32'd1);
        chk("c1_stall", {31'd0, stall_core}, 32'd1);
        chk("c1_act",   {31'd0, cp0_activeexception}, 32'd0);
        chk("c1_pc",    cp0_pc, 32'h0040_0010);
        tick();                                                   // cycle 2
        chk("c2_act",   {31'd0, cp0_activeexception}, 32'd0);
        tick();                                                   // cycle 3
        chk("c3_act",   {31'd0, cp0_activeexception}, 32'd1);
        chk("c3_valid", {31'd0, redirect_valid}, 32'd0);
        tick();                                                   // cycle 4
        chk("c4_act",    {31'd0, cp0_activeexception}, 32'd0);
        chk("c4_valid",  {31'd0, redirect_valid}, 32'd1);
        chk("c4_target", redirect_target, 32'h8000_0180);
        tick();                                                   // cycle 5
        tick();                                                   // cycle 6
        redirect_ack = 1;
        chk("c6_valid", {31'd0, redirect_valid}, 32'd1);
        tick();                                                   // cycle 7
        redirect_ack = 0;
        chk("c7_valid", {31'd0, redirect_valid}, 32'd0);
        chk("c7_inh",   {31'd0, in_handler}, 32'd1);
        chk("c7_busy",  {31'd0, busy}, 32'd0);

        // Nested trap with simultaneous ERET; ERET held one extra cycle while busy.
        pendingexception = 1; eret_commit = 1; instr_boundary = 1; commit_pc = 32'h0040_0020;
        tick();
        pendingexception = 0;
        tick();
        eret_commit = 0; instr_boundary = 0;
        begin : wait_nest
            for (int i = 0; i < 20; i++) begin
                if (redirect_valid) disable wait_nest;
                tick();
            end
            chk("nest_timeout", 32'd1, 32'd0);
        end
        chk("nest_target", redirect_target, 32'h8000_0180);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        chk("nest_pc",   cp0_pc, 32'h0040_0020);
        chk("nest_inh",  {31'd0, in_handler}, 32'd1);
        chk("nest_act",  n_act, 32'd2);
        chk("nest_eret", n_eret, 32'd0);

        // ERET with ack withheld; epc changes after entry must not leak through.
        epc = 32'h0040_0014; eret_commit = 1; instr_boundary = 1;
        tick();
        eret_commit = 0; instr_boundary = 0; epc = 32'hDEAD_BEEF;
        chk("ret_eret",   {31'd0, cp0_eret}, 32'd1);
        chk("ret_flush",  {31'd0, flush}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("ret_hold_valid",  {31'd0, redirect_valid}, 32'd1);
            chk("ret_hold_target", redirect_target, 32'h0040_0014);
            tick();
        end
        chk("ret_eret_once", {31'd0, cp0_eret}, 32'd0);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        chk("ret_valid_drop", {31'd0, redirect_valid}, 32'd0);
        chk("ret_inh",        {31'd0, in_handler}, 32'd0);
        chk("ret_eret_cnt",   n_eret, 32'd1);
`ifdef TRAP_STATS_EN
        chk("stat_trap", {16'd0, trap_count}, 32'd2);
        chk("stat_eret", {16'd0, eret_count}, 32'd1);
`endif

        // Reset while a redirect is outstanding.
        pendingexception = 1; instr_boundary = 1; commit_pc = 32'h0040_0030;
        tick();
        pendingexception = 0; instr_boundary = 0;
        begin : wait_rd
            for (int i = 0; i < 20; i++) begin
                if (redirect_valid) disable wait_rd;
                tick();
            end
            chk("rd_timeout", 32'd1, 32'd0);
        end
        reset = 1;
        tick();
        reset = 0;
        chk("rrd_valid",  {31'd0, redirect_valid}, 32'd0);
        chk("rrd_busy",   {31'd0, busy}, 32'd0);
        chk("rrd_flush",  {31'd0, flush}, 32'd0);
        chk("rrd_target", redirect_target, 32'd0);
        chk("rrd_pc",     cp0_pc, 32'd0);
        tick();
        chk("rrd_idle",   {31'd0, busy}, 32'd0);

        // Timer interrupt.
        compare = 32'h100; count = 32'hFF;
        tick();
        chk("tmr_none", {31'd0, timer_irq}, 32'd0);
        count = 32'h100;
        tick();
        chk("tmr_set", {31'd0, timer_irq}, 32'd1);
        count = 32'h101;
        tick();
        chk("tmr_sticky", {31'd0, timer_irq}, 32'd1);
        count = 32'h0;
        tick();
        chk("tmr_wrap", {31'd0, timer_irq}, 32'd1);
        count = 32'h100; compare_write = 1;
        tick();
        chk("tmr_clr_prio", {31'd0, timer_irq}, 32'd0);
        compare_write = 0; count = 32'h105;
        tick();
        chk("tmr_stay_clr", {31'd0, timer_irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
